// File: rtl/ddsm_skew_delay.sv
// ddsm_skew_delay: per-channel staggered delay chains with stall, flush, valid tracking and a primed flag
module ddsm_skew_delay #(
  parameter int P_WIDTH      = 8,
  parameter int P_CHANNELS   = 3,
  parameter int P_BASE_DELAY = 1,
  parameter int P_STEP_DELAY = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_en,
  input  logic                          i_flush,
  input  logic                          i_valid,
  input  logic [P_WIDTH*P_CHANNELS-1:0] i_data,
  output logic [P_WIDTH*P_CHANNELS-1:0] o_data,
  output logic [P_CHANNELS-1:0]         o_valid,
  output logic                          o_primed
);
  localparam int D_MAX = P_BASE_DELAY + P_STEP_DELAY * (P_CHANNELS - 1);
  localparam int CW = $clog2(D_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(D_MAX);
  if (P_BASE_DELAY < 1 || P_STEP_DELAY < 0) begin : g_bad
    $error("ddsm_skew_delay: P_BASE_DELAY must be >= 1 and P_STEP_DELAY >= 0");
  end
  logic clr;
  assign clr = !i_rst_n || i_flush;
  // each stage carries {valid, word} so the sideband stays locked to its data
  for (genvar c = 0; c < P_CHANNELS; c++) begin : g_ch
    localparam int D = P_BASE_DELAY + P_STEP_DELAY * c;
    logic [P_WIDTH:0] st [D];
    always_ff @(posedge i_clk) begin
      if (clr) begin
        for (int k = 0; k < D; k++) st[k] <= '0;
      end else if (i_en) begin
        st[0] <= {i_valid, i_data[c*P_WIDTH +: P_WIDTH]};
        for (int k = 1; k < D; k++) st[k] <= st[k-1];
      end
    end
    assign o_data[c*P_WIDTH +: P_WIDTH] = st[D-1][P_WIDTH-1:0];
    assign o_valid[c] = st[D-1][P_WIDTH];
  end
  logic [CW-1:0] cnt, cnt_nx;
  assign cnt_nx = (i_valid && cnt != CMAX) ? cnt + CW'(1) : cnt;
  always_ff @(posedge i_clk) begin
    if (clr) begin
      cnt      <= '0;
      o_primed <= 1'b0;
    end else if (i_en) begin
      cnt      <= cnt_nx;
      o_primed <= cnt_nx == CMAX;
    end
  end
endmodule

// File: tb/tb_ddsm_skew_delay.sv
// tb_ddsm_skew_delay: directed checks of latency, stall, flush, reset priority, sparse valid and a 4-channel build
module tb_ddsm_skew_delay;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0, en = 1'b0, flush = 1'b0, valid = 1'b0;
  logic [23:0] data = '0;
  logic [23:0] odata;
  logic [2:0]  ovalid;
  logic        primed;
  logic [47:0] data4 = '0;
  logic [47:0] odata4;
  logic [3:0]  ovalid4;
  logic        primed4;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  ddsm_skew_delay dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_flush(flush), .i_valid(valid),
    .i_data(data), .o_data(odata), .o_valid(ovalid), .o_primed(primed)
  );

  ddsm_skew_delay #(.P_WIDTH(12), .P_CHANNELS(4), .P_BASE_DELAY(2), .P_STEP_DELAY(1)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_flush(flush), .i_valid(valid),
    .i_data(data4), .o_data(odata4), .o_valid(ovalid4), .o_primed(primed4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; en = 1'b1; valid = 1'b0; data = '0; data4 = '0;
    step();
    rst_n = 1'b1;
  endtask

  // one word then zeros with continuous valid: word c emerges after D(c)=1/3/5 cycles
  task automatic run_fill(input string tag, input logic [23:0] w);
    for (int i = 0; i < 5; i++) begin
      en = 1'b1; flush = 1'b0; valid = 1'b1; data = (i == 0) ? w : 24'h0;
      step();
      chk({tag, "_data"}, 64'(odata), 64'((i == 0) ? (w & 24'h0000FF) :
                                          (i == 2) ? (w & 24'h00FF00) :
                                          (i == 4) ? (w & 24'hFF0000) : 24'h0));
      chk({tag, "_valid"}, 64'(ovalid), 64'((i < 2) ? 3'b001 : (i < 4) ? 3'b011 : 3'b111));
      chk({tag, "_primed"}, 64'(primed), 64'(i == 4));
    end
  endtask

  function automatic logic [23:0] ramp_exp(input int e);
    logic [23:0] r;
    for (int c = 0; c < 3; c++) begin
      int v;
      v = e + 2 - (1 + 2 * c);
      r[c*8 +: 8] = (v >= 1) ? 8'(v) : 8'h0;
    end
    return r;
  endfunction

  function automatic logic [2:0] ramp_vexp(input int e);
    logic [2:0] r;
    for (int c = 0; c < 3; c++) r[c] = (e + 2 - (1 + 2 * c)) >= 1;
    return r;
  endfunction

  initial begin
    logic [15:0] pat;
    logic [47:0] w4;
    logic [2:0]  vx;
    logic [47:0] ex4;
    do_reset();
    chk("rst_data", 64'(odata), 64'h0);
    chk("rst_valid", 64'(ovalid), 64'h0);
    chk("rst_primed", 64'(primed), 64'h0);
    chk("rst_data4", 64'(odata4), 64'h0);
    chk("rst_primed4", 64'(primed4), 64'h0);

    run_fill("fill", 24'hA53C81);

    do_reset();
    for (int e = 0; e < 6; e++) begin
      en = 1'b1; valid = 1'b1; data = {3{8'(e + 1)}};
      step();
      chk("ramp_data", 64'(odata), 64'(ramp_exp(e)));
      chk("ramp_valid", 64'(ovalid), 64'(ramp_vexp(e)));
    end
    for (int s = 0; s < 2; s++) begin
      en = 1'b0; valid = 1'b0; data = 24'hEEEEEE;
      step();
      chk("stall_data", 64'(odata), 64'(ramp_exp(5)));
      chk("stall_valid", 64'(ovalid), 64'h7);
      chk("stall_primed", 64'(primed), 64'h1);
    end
    for (int e = 6; e < 10; e++) begin
      en = 1'b1; valid = 1'b1; data = {3{8'(e + 1)}};
      step();
      chk("resume_data", 64'(odata), 64'(ramp_exp(e)));
      chk("resume_valid", 64'(ovalid), 64'h7);
    end

    en = 1'b0; flush = 1'b1; valid = 1'b1; data = 24'h777777;
    step();
    chk("flush_data", 64'(odata), 64'h0);
    chk("flush_valid", 64'(ovalid), 64'h0);
    chk("flush_primed", 64'(primed), 64'h0);
    flush = 1'b0;
    run_fill("refill", 24'h5A5A5A);

    for (int i = 0; i < 2; i++) begin
      en = 1'b1; valid = 1'b1; data = 24'h123456;
      step();
    end
    rst_n = 1'b0; flush = 1'b1; en = 1'b1; valid = 1'b1; data = 24'hFFFFFF;
    step();
    chk("rstpri_data", 64'(odata), 64'h0);
    chk("rstpri_valid", 64'(ovalid), 64'h0);
    chk("rstpri_primed", 64'(primed), 64'h0);
    rst_n = 1'b1; flush = 1'b0;
    run_fill("recover", 24'hA53C81);

    // valid on edges 0,2,3,5,6: the fifth valid is accepted on edge 6
    do_reset();
    pat = 16'b0000_0000_0110_1101;
    for (int e = 0; e < 12; e++) begin
      en = 1'b1; valid = pat[e]; data = '0;
      step();
      for (int c = 0; c < 3; c++) begin
        int idx;
        idx = e + 1 - (1 + 2 * c);
        vx[c] = (idx >= 0) ? pat[idx] : 1'b0;
      end
      chk("sparse_valid", 64'(ovalid), 64'(vx));
      chk("sparse_primed", 64'(primed), 64'(e >= 6));
    end

    do_reset();
    w4 = {12'h5E7, 12'h9F0, 12'h123, 12'hABC};
    for (int i = 0; i < 6; i++) begin
      en = 1'b1; valid = 1'b1; data4 = (i == 0) ? w4 : 48'h0;
      step();
      for (int c = 0; c < 4; c++) ex4[c*12 +: 12] = (i == c + 1) ? w4[c*12 +: 12] : 12'h0;
      chk("p4_data", 64'(odata4), 64'(ex4));
      chk("p4_valid", 64'(ovalid4), 64'((i >= 4) ? 4'hF : (i == 3) ? 4'h7 :
                                        (i == 2) ? 4'h3 : (i == 1) ? 4'h1 : 4'h0));
      chk("p4_primed", 64'(primed4), 64'(i >= 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
